// File: rtl/spi_mult_frame_engine_if.sv
// Frame-level handshake between the SPI slave shift logic and the multiply engine.
// The master side drives received frames and tx completion; the slave side returns results and status.
interface spi_mult_frame_engine_if;
  logic        rx_valid;
  logic [15:0] mosi_reg_data;
  logic        tx_done;
  logic [15:0] miso_reg_data;
  logic        busy;
  logic        result_valid;
  logic        overrun_err;

  modport master (
    output rx_valid,
    output mosi_reg_data,
    output tx_done,
    input  miso_reg_data,
    input  busy,
    input  result_valid,
    input  overrun_err
  );

  modport slave (
    input  rx_valid,
    input  mosi_reg_data,
    input  tx_done,
    output miso_reg_data,
    output busy,
    output result_valid,
    output overrun_err
  );
endinterface

// File: rtl/spi_mult_frame_engine.sv
// Two-frame SPI multiplier: receives A then B, runs a 16-step shift-add, returns P high then low.
// Define MULT_SIGNED_EN for a two's-complement multiply; otherwise operands and product are unsigned.
module spi_mult_frame_engine (
  input  logic                        clk,
  input  logic                        reset,
  spi_mult_frame_engine_if.slave      bus
);
  localparam int DATA_W = 16;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, GET_B, MULT, SEND_HI, SEND_LO} state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [2*DATA_W-1:0] prod;
  logic [3:0]          step;
  logic                overrun;

  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] partial;
  logic [2*DATA_W-1:0] prod_sum;
  logic [2*DATA_W-1:0] prod_final;
  logic                neg_result;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return (SIGNED_EN && v[DATA_W-1]) ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] mag,
                                                     input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  // Shift-add step: the first step starts from zero so the product register needs no clear outside MULT.
  always_comb begin
    a_mag      = magnitude(op_a);
    b_mag      = magnitude(op_b);
    partial    = b_mag[step] ? ({16'd0, a_mag} << step) : 32'd0;
    prod_sum   = ((step == 4'd0) ? 32'd0 : prod) + partial;
    neg_result = SIGNED_EN && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
    prod_final = apply_sign(prod_sum, neg_result);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.rx_valid) state_next = GET_B;
      GET_B:   if (bus.rx_valid) state_next = MULT;
      MULT:    if (step == 4'd15) state_next = SEND_HI;
      SEND_HI: if (bus.tx_done) state_next = SEND_LO;
      SEND_LO: if (bus.tx_done) state_next = bus.rx_valid ? GET_B : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand, product and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a    <= '0;
      op_b    <= '0;
      prod    <= '0;
      step    <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_valid) op_a <= bus.mosi_reg_data;
        end
        GET_B: begin
          if (bus.rx_valid) begin
            op_b <= bus.mosi_reg_data;
            step <= 4'd0;
          end
        end
        MULT: begin
          step <= step + 4'd1;
          prod <= (step == 4'd15) ? prod_final : prod_sum;
        end
        SEND_LO: begin
          if (bus.rx_valid && bus.tx_done) op_a <= bus.mosi_reg_data;
        end
        default: ;
      endcase
      if (bus.rx_valid && ((state == MULT) || (state == SEND_HI) ||
                           ((state == SEND_LO) && !bus.tx_done)))
        overrun <= 1'b1;
    end
  end

  always_comb begin
    bus.busy          = (state == MULT) || (state == SEND_HI) || (state == SEND_LO);
    bus.result_valid  = (state == SEND_HI) || (state == SEND_LO);
    bus.overrun_err   = overrun;
    bus.miso_reg_data = '0;
    if (state == SEND_HI)      bus.miso_reg_data = prod[2*DATA_W-1:DATA_W];
    else if (state == SEND_LO) bus.miso_reg_data = prod[DATA_W-1:0];
  end
endmodule

// File: doc/spi_mult_frame_engine.md
SPI_MULT_FRAME_ENGINE -- requirements
Module: spi_mult_frame_engine

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 rx_valid  input  1  one-cycle pulse from the upstream SPI slave: mosi_reg_data holds a complete received frame.
REQ-005 mosi_reg_data  input  16  received frame; sampled only in a cycle where rx_valid=1.
REQ-006 tx_done  input  1  one-cycle pulse from the SPI slave: current miso_reg_data frame has been shifted out.
REQ-007 miso_reg_data  output  16  frame the SPI slave transmits next.
REQ-008 busy  output  1  high in MULT, SEND_HI and SEND_LO.
REQ-009 result_valid  output  1  high in SEND_HI and SEND_LO.
REQ-010 overrun_err  output  1  sticky flag: a frame arrived and was dropped.

Function
REQ-011 SHALL implement FSM states IDLE, GET_B, MULT, SEND_HI and SEND_LO.
REQ-012 IDLE: on rx_valid, latch mosi_reg_data as operand A and go to GET_B.
REQ-013 GET_B: on rx_valid, latch operand B, clear the step counter and go to MULT.
REQ-014 MULT: one shift-add step per cycle for exactly 16 cycles, using a 32-bit product register and a 4-bit step counter.
REQ-015 MULT latency: if B is accepted in cycle T, the FSM SHALL enter SEND_HI in cycle T+17, with result_valid=1 and miso_reg_data=P[31:16].
REQ-016 SEND_HI: on tx_done, set miso_reg_data=P[15:0] and go to SEND_LO.
REQ-017 SEND_LO: on tx_done, set miso_reg_data=0 and result_valid=0, then go to IDLE.
REQ-018 rx_valid in MULT, SEND_HI, or SEND_LO without tx_done: drop the frame, set overrun_err=1, leave the FSM, operands and product unchanged.
REQ-019 SEND_LO with rx_valid and tx_done in the same cycle: latch the frame as operand A and go to GET_B; no error.
REQ-020 tx_done in IDLE, GET_B or MULT SHALL be ignored.
REQ-021 Product is a full 32-bit result with no truncation.
REQ-022 The product register SHALL only be written in MULT.
REQ-023 miso_reg_data SHALL be 0 in every state except SEND_HI and SEND_LO.

Reset
REQ-024 reset SHALL force the following, in any state including mid-MULT: state=IDLE; A, B, P and step counter = 0; miso_reg_data=0; busy=0; result_valid=0; overrun_err=0.
REQ-025 reset SHALL take priority over rx_valid and tx_done in the same cycle.
REQ-026 overrun_err SHALL clear only by reset.

Configuration
REQ-027 Macro MULT_SIGNED_EN SHALL select signedness.
REQ-028 With MULT_SIGNED_EN defined: A and B are 16-bit two's complement and P is the 32-bit two's-complement product. Implementation: multiply magnitudes, then negate if the operand signs differ. MULT latency is unchanged (REQ-015).
REQ-029 Without MULT_SIGNED_EN: A, B and P are unsigned.

Verification
REQ-030 Unsigned build: rx A=0xF1F1, rx B=0x0002 -> result_valid exactly 17 cycles after B; miso_reg_data=0x0001; after tx_done =0xE3E2; after tx_done =0x0000 and back in IDLE.
REQ-031 A=0xFFFF, B=0xFFFF -> unsigned build: 0xFFFE then 0x0001; signed build: 0x0000 then 0x0001.
REQ-032 A=0x8000, B=0x0002 -> unsigned build: 0x0001/0x0000; signed build: 0xFFFF/0x0000.
REQ-033 Extra rx_valid with data 0x1234 in cycle 5 of MULT -> overrun_err=1 and stays 1; result of the original A×B unaffected.
REQ-034 In SEND_LO, assert rx_valid (data 0x0003) and tx_done together -> state GET_B, overrun_err stays 0. Then rx B=0x0004 -> result 0x0000/0x000C.
REQ-035 reset asserted in cycle 8 of MULT -> next cycle: IDLE, busy=0, miso_reg_data=0. A following A=3, B=5 sequence yields 0x0000/0x000F.
